// File: rtl/dual_port_memory_if.sv
// Bus bundle for dual_port_memory: both access ports plus status outputs.
// master drives requests (i_*), slave drives responses (o_*).
interface dual_port_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  i_a_en;
    logic                  i_a_wr_en;
    logic [NUM_BYTES-1:0]  i_a_be;
    logic [ADDR_WIDTH-1:0] i_a_address;
    logic [DATA_WIDTH-1:0] i_a_wr_data;
    logic [DATA_WIDTH-1:0] o_a_rd_data;
    logic                  o_a_rd_valid;
    logic                  o_a_parity_err;

    logic                  i_b_en;
    logic                  i_b_wr_en;
    logic [NUM_BYTES-1:0]  i_b_be;
    logic [ADDR_WIDTH-1:0] i_b_address;
    logic [DATA_WIDTH-1:0] i_b_wr_data;
    logic [DATA_WIDTH-1:0] o_b_rd_data;
    logic                  o_b_rd_valid;
    logic                  o_b_parity_err;

    logic                  o_collision;

    modport master (
        output i_a_en, i_a_wr_en, i_a_be, i_a_address, i_a_wr_data,
        output i_b_en, i_b_wr_en, i_b_be, i_b_address, i_b_wr_data,
        input  o_a_rd_data, o_a_rd_valid, o_a_parity_err,
        input  o_b_rd_data, o_b_rd_valid, o_b_parity_err,
        input  o_collision
    );

    modport slave (
        input  i_a_en, i_a_wr_en, i_a_be, i_a_address, i_a_wr_data,
        input  i_b_en, i_b_wr_en, i_b_be, i_b_address, i_b_wr_data,
        output o_a_rd_data, o_a_rd_valid, o_a_parity_err,
        output o_b_rd_data, o_b_rd_valid, o_b_parity_err,
        output o_collision
    );
endinterface

// File: rtl/dual_port_memory.sv
// True dual-port RAM, byte-enabled writes, RD_LATENCY-deep read pipes.
// Ports: i_clk, i_rst_n (async low), bus (dual_port_memory_if.slave).
// Option: define DUAL_PORT_MEMORY_PARITY_EN for per-lane even parity.
module dual_port_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    dual_port_memory_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  en       [2];
    logic                  wr_en    [2];
    logic [NUM_BYTES-1:0]  be       [2];
    logic [ADDR_WIDTH-1:0] addr     [2];
    logic [DATA_WIDTH-1:0] wr_data  [2];
    logic [DATA_WIDTH-1:0] rd_data  [2];
    logic                  rd_valid [2];
    logic                  par_err  [2];
    logic                  collision;

    assign en[0]      = bus.i_a_en;
    assign wr_en[0]   = bus.i_a_wr_en;
    assign be[0]      = bus.i_a_be;
    assign addr[0]    = bus.i_a_address;
    assign wr_data[0] = bus.i_a_wr_data;
    assign en[1]      = bus.i_b_en;
    assign wr_en[1]   = bus.i_b_wr_en;
    assign be[1]      = bus.i_b_be;
    assign addr[1]    = bus.i_b_address;
    assign wr_data[1] = bus.i_b_wr_data;

    assign bus.o_a_rd_data    = rd_data[0];
    assign bus.o_a_rd_valid   = rd_valid[0];
    assign bus.o_a_parity_err = par_err[0];
    assign bus.o_b_rd_data    = rd_data[1];
    assign bus.o_b_rd_valid   = rd_valid[1];
    assign bus.o_b_parity_err = par_err[1];
    assign bus.o_collision    = collision;

`ifdef DUAL_PORT_MEMORY_PARITY_EN
    logic [NUM_BYTES-1:0] par [DEPTH];

    function automatic logic [NUM_BYTES-1:0] lane_par(
        input logic [DATA_WIDTH-1:0] w
    );
        logic [NUM_BYTES-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_BYTES; i++)
            r[i] = ^w[i*BYTE_WIDTH +: BYTE_WIDTH];
        return r;
    endfunction
`endif

    // Port B is applied first so port A's later NBA wins on shared lanes.
    always_ff @(posedge i_clk) begin
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (en[p] && wr_en[p] && be[p][i]) begin
                    mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        wr_data[p][i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef DUAL_PORT_MEMORY_PARITY_EN
                    par[addr[p]][i] <=
                        ^wr_data[p][i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= en[0] & wr_en[0] & en[1] & wr_en[1]
                       & (addr[0] == addr[1]);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] s_d [RD_LATENCY];
        logic [RD_LATENCY-1:0] s_v;
        logic [DATA_WIDTH-1:0] d_q [RD_LATENCY];
        logic [RD_LATENCY-1:0] v_q;

        // Stage inputs: array word (sampled pre-write) then prior stage.
        always_comb begin
            s_v    = '0;
            s_d[0] = mem[addr[p]];
            s_v[0] = en[p] & ~wr_en[p];
            for (int i = 1; i < RD_LATENCY; i++) begin
                s_d[i] = d_q[i-1];
                s_v[i] = v_q[i-1];
            end
        end

        // Data only moves with its valid, so the last stage holds.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_q <= '0;
                for (int i = 0; i < RD_LATENCY; i++)
                    d_q[i] <= '0;
            end else begin
                v_q <= s_v;
                for (int i = 0; i < RD_LATENCY; i++)
                    if (s_v[i])
                        d_q[i] <= s_d[i];
            end
        end

        assign rd_data[p]  = d_q[RD_LATENCY-1];
        assign rd_valid[p] = v_q[RD_LATENCY-1];

`ifdef DUAL_PORT_MEMORY_PARITY_EN
        logic [RD_LATENCY-1:0] s_e;
        logic [RD_LATENCY-1:0] e_q;

        always_comb begin
            s_e    = '0;
            s_e[0] = |(par[addr[p]] ^ lane_par(mem[addr[p]]));
            for (int i = 1; i < RD_LATENCY; i++)
                s_e[i] = e_q[i-1];
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                e_q <= '0;
            else
                e_q <= s_e & s_v;
        end

        assign par_err[p] = e_q[RD_LATENCY-1];
`else
        assign par_err[p] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_dual_port_memory.sv
// Directed bench for dual_port_memory at RD_LATENCY 1 and 3.
// Prints one "passed/total checks passed" line at the end.
module tb_dual_port_memory;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    dual_port_memory_if bus1 ();
    dual_port_memory_if bus3 ();

    dual_port_memory #(.RD_LATENCY(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    dual_port_memory #(.RD_LATENCY(3)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                         input logic [7:0] ad, input logic [31:0] d);
        bus1.i_a_en = en; bus1.i_a_wr_en = we; bus1.i_a_be = be;
        bus1.i_a_address = ad; bus1.i_a_wr_data = d;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                         input logic [7:0] ad, input logic [31:0] d);
        bus1.i_b_en = en; bus1.i_b_wr_en = we; bus1.i_b_be = be;
        bus1.i_b_address = ad; bus1.i_b_wr_data = d;
    endtask

    task automatic set_a3(input logic en, input logic we, input logic [3:0] be,
                          input logic [7:0] ad, input logic [31:0] d);
        bus3.i_a_en = en; bus3.i_a_wr_en = we; bus3.i_a_be = be;
        bus3.i_a_address = ad; bus3.i_a_wr_data = d;
    endtask

    task automatic idle();
        set_a(0, 0, 4'h0, 8'h00, 32'h0);
        set_b(0, 0, 4'h0, 8'h00, 32'h0);
        set_a3(0, 0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus3.i_b_en = 0; bus3.i_b_wr_en = 0; bus3.i_b_be = 0;
        bus3.i_b_address = 0; bus3.i_b_wr_data = 0;
        step();
        step();
        total++; if (bus1.o_a_rd_valid !== 1'b0) $display("FAIL reset_a_valid got %b want 0", bus1.o_a_rd_valid); else passed++;
        total++; if (bus1.o_a_rd_data !== 32'h0) $display("FAIL reset_a_data got %h want 0", bus1.o_a_rd_data); else passed++;
        total++; if (bus1.o_b_rd_valid !== 1'b0) $display("FAIL reset_b_valid got %b want 0", bus1.o_b_rd_valid); else passed++;
        total++; if (bus1.o_b_rd_data !== 32'h0) $display("FAIL reset_b_data got %h want 0", bus1.o_b_rd_data); else passed++;
        total++; if (bus1.o_collision !== 1'b0) $display("FAIL reset_collision got %b want 0", bus1.o_collision); else passed++;
        total++; if (bus1.o_a_parity_err !== 1'b0) $display("FAIL reset_parity got %b want 0", bus1.o_a_parity_err); else passed++;
        total++; if (bus3.o_a_rd_valid !== 1'b0) $display("FAIL reset_l3_valid got %b want 0", bus3.o_a_rd_valid); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_rw();
        set_a(1, 1, 4'hF, 8'h10, 32'hDEADBEEF);
        step();
        set_a(1, 0, 4'h0, 8'h10, 32'h0);
        step();
        total++; if (bus1.o_a_rd_valid !== 1'b1) $display("FAIL basic_a_valid got %b want 1", bus1.o_a_rd_valid); else passed++;
        total++; if (bus1.o_a_rd_data !== 32'hDEADBEEF) $display("FAIL basic_a_data got %h want deadbeef", bus1.o_a_rd_data); else passed++;
        set_a(0, 0, 4'h0, 8'h00, 32'h0);
        set_b(1, 0, 4'h0, 8'h10, 32'h0);
        step();
        total++; if (bus1.o_b_rd_valid !== 1'b1) $display("FAIL basic_b_valid got %b want 1", bus1.o_b_rd_valid); else passed++;
        total++; if (bus1.o_b_rd_data !== 32'hDEADBEEF) $display("FAIL basic_b_data got %h want deadbeef", bus1.o_b_rd_data); else passed++;
        total++; if (bus1.o_a_rd_valid !== 1'b0) $display("FAIL basic_a_pulse got %b want 0", bus1.o_a_rd_valid); else passed++;
        total++; if (bus1.o_a_rd_data !== 32'hDEADBEEF) $display("FAIL basic_a_hold got %h want deadbeef", bus1.o_a_rd_data); else passed++;
        idle();
        step();
    endtask

    task automatic test_byte_enable();
        set_a(1, 1, 4'hF, 8'h20, 32'h11223344);
        step();
        set_a(0, 0, 4'h0, 8'h00, 32'h0);
        set_b(1, 1, 4'b0101, 8'h20, 32'hAABBCCDD);
        step();
        set_b(0, 0, 4'h0, 8'h00, 32'h0);
        set_a(1, 0, 4'h0, 8'h20, 32'h0);
        step();
        total++; if (bus1.o_a_rd_data !== 32'h11BB33DD) $display("FAIL be_merge got %h want 11bb33dd", bus1.o_a_rd_data); else passed++;
        set_a(0, 0, 4'h0, 8'h00, 32'h0);
        set_b(1, 1, 4'h0, 8'h20, 32'hFFFFFFFF);
        step();
        set_b(1, 0, 4'h0, 8'h20, 32'h0);
        step();
        total++; if (bus1.o_b_rd_data !== 32'h11BB33DD) $display("FAIL be_zero_noop got %h want 11bb33dd", bus1.o_b_rd_data); else passed++;
        idle();
        step();
    endtask

    task automatic test_collision();
        set_a(1, 1, 4'hF, 8'h30, 32'h00000001);
        set_b(1, 1, 4'hF, 8'h30, 32'hFFFFFFFF);
        step();
        total++; if (bus1.o_collision !== 1'b1) $display("FAIL coll_flag got %b want 1", bus1.o_collision); else passed++;
        set_b(0, 0, 4'h0, 8'h00, 32'h0);
        set_a(1, 0, 4'h0, 8'h30, 32'h0);
        step();
        total++; if (bus1.o_collision !== 1'b0) $display("FAIL coll_pulse got %b want 0", bus1.o_collision); else passed++;
        total++; if (bus1.o_a_rd_data !== 32'h00000001) $display("FAIL coll_a_wins got %h want 00000001", bus1.o_a_rd_data); else passed++;
        set_a(1, 1, 4'hF, 8'h34, 32'h0);
        step();
        set_a(1, 1, 4'b0011, 8'h34, 32'h11111111);
        set_b(1, 1, 4'b0110, 8'h34, 32'h22222222);
        step();
        set_b(0, 0, 4'h0, 8'h00, 32'h0);
        set_a(1, 0, 4'h0, 8'h34, 32'h0);
        step();
        total++; if (bus1.o_a_rd_data !== 32'h00221111) $display("FAIL coll_lane_merge got %h want 00221111", bus1.o_a_rd_data); else passed++;
        idle();
        step();
    endtask

    task automatic test_read_first();
        set_a(1, 1, 4'hF, 8'h40, 32'h5);
        step();
        set_a(1, 1, 4'hF, 8'h40, 32'h9);
        set_b(1, 0, 4'h0, 8'h40, 32'h0);
        step();
        total++; if (bus1.o_b_rd_data !== 32'h5) $display("FAIL rf_old_data got %h want 5", bus1.o_b_rd_data); else passed++;
        total++; if (bus1.o_collision !== 1'b0) $display("FAIL rf_no_coll got %b want 0", bus1.o_collision); else passed++;
        set_a(1, 0, 4'h0, 8'h40, 32'h0);
        step();
        total++; if (bus1.o_b_rd_data !== 32'h9) $display("FAIL rf_new_b got %h want 9", bus1.o_b_rd_data); else passed++;
        total++; if (bus1.o_a_rd_data !== 32'h9) $display("FAIL rf_new_a got %h want 9", bus1.o_a_rd_data); else passed++;
        total++; if (bus1.o_a_rd_valid !== 1'b1 || bus1.o_b_rd_valid !== 1'b1) $display("FAIL rf_both_valid got %b%b want 11", bus1.o_a_rd_valid, bus1.o_b_rd_valid); else passed++;
        idle();
        step();
    endtask

    task automatic test_latency3();
        logic exp_v;
        for (int i = 0; i < 8; i++) begin
            set_a3(1, 1, 4'hF, 8'(i), 32'h100 + 32'(i));
            step();
        end
        for (int k = 0; k < 11; k++) begin
            if (k < 8) set_a3(1, 0, 4'h0, 8'(k), 32'h0);
            else set_a3(0, 0, 4'h0, 8'h00, 32'h0);
            step();
            exp_v = (k >= 2 && k <= 9);
            total++; if (bus3.o_a_rd_valid !== exp_v) $display("FAIL l3_valid_%0d got %b want %b", k, bus3.o_a_rd_valid, exp_v); else passed++;
            if (exp_v) begin
                total++; if (bus3.o_a_rd_data !== 32'h100 + 32'(k - 2)) $display("FAIL l3_data_%0d got %h want %h", k, bus3.o_a_rd_data, 32'h100 + 32'(k - 2)); else passed++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            set_a3(1, 0, 4'h0, 8'(k), 32'h0);
            step();
        end
        total++; if (bus3.o_a_rd_valid !== 1'b1) $display("FAIL l3_pre_rst got %b want 1", bus3.o_a_rd_valid); else passed++;
        rst_n = 1'b0;
        idle();
        #1;
        total++; if (bus3.o_a_rd_valid !== 1'b0) $display("FAIL l3_rst_drop got %b want 0", bus3.o_a_rd_valid); else passed++;
        total++; if (bus3.o_a_rd_data !== 32'h0) $display("FAIL l3_rst_data got %h want 0", bus3.o_a_rd_data); else passed++;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (bus3.o_a_rd_valid !== 1'b0) $display("FAIL l3_no_pulse_%0d got %b want 0", k, bus3.o_a_rd_valid); else passed++;
        end
        set_a3(1, 0, 4'h0, 8'h03, 32'h0);
        step();
        set_a3(0, 0, 4'h0, 8'h00, 32'h0);
        step();
        step();
        total++; if (bus3.o_a_rd_valid !== 1'b1 || bus3.o_a_rd_data !== 32'h103) $display("FAIL l3_mem_kept got %b/%h want 1/103", bus3.o_a_rd_valid, bus3.o_a_rd_data); else passed++;
        step();
    endtask

    task automatic test_parity();
`ifdef DUAL_PORT_MEMORY_PARITY_EN
        set_a(1, 1, 4'hF, 8'h50, 32'hA5A5A5A5);
        step();
        set_a(1, 0, 4'h0, 8'h50, 32'h0);
        step();
        total++; if (bus1.o_a_parity_err !== 1'b0) $display("FAIL par_clean got %b want 0", bus1.o_a_parity_err); else passed++;
        set_a(0, 0, 4'h0, 8'h00, 32'h0);
        dut1.mem[8'h50][16] = ~dut1.mem[8'h50][16];
        step();
        set_a(1, 0, 4'h0, 8'h50, 32'h0);
        step();
        total++; if (bus1.o_a_parity_err !== 1'b1 || bus1.o_a_rd_valid !== 1'b1) $display("FAIL par_err got %b/%b want 1/1", bus1.o_a_parity_err, bus1.o_a_rd_valid); else passed++;
        set_a(1, 0, 4'h0, 8'h10, 32'h0);
        step();
        total++; if (bus1.o_a_parity_err !== 1'b0) $display("FAIL par_other got %b want 0", bus1.o_a_parity_err); else passed++;
`else
        set_a(1, 0, 4'h0, 8'h10, 32'h0);
        step();
        total++; if (bus1.o_a_parity_err !== 1'b0 || bus1.o_a_rd_valid !== 1'b1) $display("FAIL par_tied got %b/%b want 0/1", bus1.o_a_parity_err, bus1.o_a_rd_valid); else passed++;
`endif
        idle();
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_basic_rw();
        test_byte_enable();
        test_collision();
        test_read_first();
        test_latency3();
        test_parity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
